// File: rtl/nn_pkg.sv
// Shared fixed-point definitions and sequencer state type for the perceptron trainer.
package nn_pkg;

   localparam int SIGN = 1;
   localparam int Q_M  = 15;
   localparam int Q_N  = 16;
   localparam int W    = SIGN + Q_M + Q_N;

   typedef logic [W-1:0] fixed_t;

   localparam fixed_t FP_ONE = 32'h0001_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/sample_regfile.sv
// Training-set storage: one {x1, x2, y} record per address, synchronous write, combinational read.
module sample_regfile #(
   parameter int MAX_SAMPLES = 16,
   parameter int ADDR_W      = $clog2(MAX_SAMPLES),
   parameter int W           = 32
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [W-1:0]      wr_x1_i,
   input  logic [W-1:0]      wr_x2_i,
   input  logic [W-1:0]      wr_y_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [W-1:0]      rd_x1_o,
   output logic [W-1:0]      rd_x2_o,
   output logic [W-1:0]      rd_y_o
);

   logic [3*W-1:0] mem_q [MAX_SAMPLES];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= {wr_x1_i, wr_x2_i, wr_y_i};
      end
   end

   always_comb begin
      {rd_x1_o, rd_x2_o, rd_y_o} = mem_q[rd_addr_i];
   end

endmodule

// File: rtl/train_data_sequencer.sv
// Streams the stored training set to the trainer for a programmed number of epochs,
// holding valid_o high without gaps for the whole run.
module train_data_sequencer #(
   parameter int SIGN        = 1,
   parameter int Q_M         = 15,
   parameter int Q_N         = 16,
   parameter int MAX_SAMPLES = 16,
   parameter int ADDR_W      = $clog2(MAX_SAMPLES),
   parameter int EPOCH_W     = 16,
   localparam int W          = SIGN + Q_M + Q_N
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               wr_en_i,
   input  logic [ADDR_W-1:0]  wr_addr_i,
   input  logic [W-1:0]       wr_x1_i,
   input  logic [W-1:0]       wr_x2_i,
   input  logic [W-1:0]       wr_y_i,
   input  logic [ADDR_W:0]    num_samples_i,
   input  logic [EPOCH_W-1:0] num_epochs_i,
   input  logic               start_i,
   input  logic               abort_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               cfg_err_o,
   output logic               valid_o,
   output logic [W-1:0]       train_x1_o,
   output logic [W-1:0]       train_x2_o,
   output logic [W-1:0]       train_out_o,
   output logic [ADDR_W-1:0]  sample_idx_o,
   output logic [EPOCH_W-1:0] epoch_o,
   output logic               last_o
);

   import nn_pkg::*;

   localparam logic [ADDR_W:0]    ONE_S = (ADDR_W+1)'(1);
   localparam logic [EPOCH_W-1:0] ONE_E = EPOCH_W'(1);
   localparam logic [ADDR_W:0]    MAX_S = (ADDR_W+1)'(MAX_SAMPLES);

   seq_state_e         state_q, state_d;
   logic [ADDR_W:0]    num_s_q, num_s_d;
   logic [EPOCH_W-1:0] num_e_q, num_e_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic               cfg_err_q, cfg_err_d;
   logic               last_q, last_d;
   logic [W-1:0]       x1_q, x1_d;
   logic [W-1:0]       x2_q, x2_d;
   logic [W-1:0]       y_q, y_d;

   logic               wr_ok;
   logic               legal_cfg;
   logic               present;
   logic               bypass;
   logic [W-1:0]       rd_x1, rd_x2, rd_y;

   assign wr_ok     = wr_en_i & ~valid_q;
   assign legal_cfg = (num_samples_i != '0) && (num_samples_i <= MAX_S) && (num_epochs_i != '0);

   sample_regfile #(
      .MAX_SAMPLES (MAX_SAMPLES),
      .ADDR_W      (ADDR_W),
      .W           (W)
   ) u_regfile (
      .clk_i     (clk_i),
      .wr_en_i   (wr_ok),
      .wr_addr_i (wr_addr_i),
      .wr_x1_i   (wr_x1_i),
      .wr_x2_i   (wr_x2_i),
      .wr_y_i    (wr_y_i),
      .rd_addr_i (idx_d),
      .rd_x1_o   (rd_x1),
      .rd_x2_o   (rd_x2),
      .rd_y_o    (rd_y)
   );

   always_comb begin
      state_d   = state_q;
      num_s_d   = num_s_q;
      num_e_d   = num_e_q;
      idx_d     = '0;
      epoch_d   = '0;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;
      present   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (legal_cfg) begin
                  num_s_d = num_samples_i;
                  num_e_d = num_epochs_i;
                  state_d = ST_RUN;
                  present = 1'b1;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            // abort wins over completion of the final sample
            if (abort_i) begin
               state_d = ST_IDLE;
            end else if (last_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               present = 1'b1;
               if ({1'b0, idx_q} == num_s_q - ONE_S) begin
                  epoch_d = epoch_q + ONE_E;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  epoch_d = epoch_q;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      valid_d = present;
      last_d  = present && ({1'b0, idx_d} == num_s_d - ONE_S) && (epoch_d == num_e_d - ONE_E);

      // a write coinciding with an accepted start must reach the first presented sample
      bypass = wr_ok && (wr_addr_i == idx_d);
      x1_d   = present ? (bypass ? wr_x1_i : rd_x1) : '0;
      x2_d   = present ? (bypass ? wr_x2_i : rd_x2) : '0;
      y_d    = present ? (bypass ? wr_y_i  : rd_y)  : '0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         num_s_q   <= '0;
         num_e_q   <= '0;
         idx_q     <= '0;
         epoch_q   <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         last_q    <= 1'b0;
         x1_q      <= '0;
         x2_q      <= '0;
         y_q       <= '0;
      end else begin
         state_q   <= state_d;
         num_s_q   <= num_s_d;
         num_e_q   <= num_e_d;
         idx_q     <= idx_d;
         epoch_q   <= epoch_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
         last_q    <= last_d;
         x1_q      <= x1_d;
         x2_q      <= x2_d;
         y_q       <= y_d;
      end
   end

   assign busy_o       = valid_q;
   assign valid_o      = valid_q;
   assign done_o       = done_q;
   assign cfg_err_o    = cfg_err_q;
   assign last_o       = last_q;
   assign train_x1_o   = x1_q;
   assign train_x2_o   = x2_q;
   assign train_out_o  = y_q;
   assign sample_idx_o = idx_q;
   assign epoch_o      = epoch_q;

endmodule

// File: doc/train_data_sequencer.md
Name: train_data_sequencer

Overview:
- Upstream stage of the single-neuron perceptron trainer.
- Holds a small training set in an internal register file (samples x1, x2 and target y, signed Q15.16), written by a host or loader.
- On start, streams the set through the trainer for a programmed number of epochs, one sample per clock.
- Drives the trainer's sample inputs and its valid input.
- Because the trainer re-initialises its weights whenever valid is low, valid_o is held high continuously for the whole run with no gaps.

Parameters:
- SIGN, 1, sign bit count of the fixed-point word.
- Q_M, 15, integer bits.
- Q_N, 16, fraction bits.
- MAX_SAMPLES, 16, register-file depth (power of two, at least 2).
- ADDR_W, $clog2(MAX_SAMPLES), sample address width.
- EPOCH_W, 16, epoch counter width.

Ports:
- Widths: W = SIGN+Q_M+Q_N (32 by default).
- clk_i  in  1  sole clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- wr_en_i  in  1  write one sample into the register file.
- wr_addr_i  in  ADDR_W  sample index to write.
- wr_x1_i, wr_x2_i, wr_y_i  in  W each  sample inputs x1, x2 and target y.
- num_samples_i  in  ADDR_W+1  samples per epoch, legal range 1..MAX_SAMPLES; sampled only on accepted start.
- num_epochs_i  in  EPOCH_W  epoch count, legal range at least 1; sampled only on accepted start.
- start_i  in  1  start request.
- abort_i  in  1  stop the run immediately.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse on normal completion.
- cfg_err_o  out  1  one-cycle pulse when start is rejected because of an illegal configuration.
- valid_o  out  1  to trainer valid_i.
- train_x1_o, train_x2_o, train_out_o  out  W each  to the trainer's x1, x2 and target inputs.
- sample_idx_o  out  ADDR_W  index of the sample currently presented.
- epoch_o  out  EPOCH_W  current epoch, counted from zero.
- last_o  out  1  high with the final sample of the final epoch.

Behaviour:
- Reset: sets state to IDLE and clears every output to 0. Register-file contents are not reset; they are undefined until written.
- States: IDLE, RUN, DONE.
- IDLE + start_i + legal configuration:
  - Latch num_samples_i and num_epochs_i.
  - Clear the sample and epoch counters.
  - Go to RUN.
  - busy_o=1 from the next cycle.
- IDLE + start_i + illegal configuration (num_samples_i=0, num_samples_i>MAX_SAMPLES, or num_epochs_i=0): cfg_err_o=1 for the next cycle, state stays IDLE.
- RUN output timing: outputs are registered. If start is accepted at edge k, then from edge k+1 valid_o=1 and the outputs present sample 0 of epoch 0.
- RUN sequencing:
  - The sample index advances by one every cycle.
  - When it reaches latched_S-1 it wraps to 0 and epoch increments.
  - valid_o stays high for exactly S*E consecutive cycles.
- Final cycle: last_o=1 together with sample S-1 of epoch E-1. The next edge enters DONE.
- DONE (one cycle):
  - done_o=1, busy_o=0, valid_o=0.
  - Data outputs are zero.
  - Returns to IDLE.
- Data outputs: all zeros whenever valid_o=0, so idle values never leak into the trainer.
- Writes:
  - Accepted only when busy_o=0 (IDLE or DONE); ignored during RUN.
  - A write and an accepted start in the same cycle: the write lands first, and the run sees the new data.
- Ignored inputs: start_i while in RUN or DONE.
- abort_i during RUN:
  - Next cycle valid_o=0 and busy_o=0, state goes to IDLE.
  - No done_o pulse.
  - abort_i takes priority over last-sample completion.
  - abort_i in IDLE has no effect.
- Reset mid-run: identical to power-on reset. The run is lost; the register file is retained.
- Epoch counter: does not wrap. The maximum count is bounded by num_epochs_i.
- Arithmetic: none on the data path. The counters are unsigned.

Decomposition:
- Shared package nn_pkg:
  - Fixed-point width localparams (SIGN, Q_M, Q_N, W).
  - Typedef fixed_t (logic [W-1:0]).
  - Constant FP_ONE = 32'h0001_0000.
  - State enum seq_state_e.
- One sub-module, sample_regfile:
  - MAX_SAMPLES x 3W storage.
  - Synchronous write.
  - Combinational read.
- The sequencer registers the read data into its output stage.

Test Plan:
- AND set loaded as (0,0,0), (0,1,0), (1,0,0), (1,1,1), with 1.0=0x00010000. S=4, E=3, start at cycle 10 -> valid_o high cycles 11-22 (12 cycles). Samples appear in order 0,1,2,3 repeating. epoch_o steps 0,1,2. last_o at cycle 22. done_o at cycle 23 only.
- Start with num_samples_i=0, then with num_epochs_i=0, then with num_samples_i=17 -> cfg_err_o pulses each time; busy_o and valid_o stay 0.
- S=1, E=1 -> exactly one valid cycle with last_o=1, then done_o the next cycle.
- Abort issued on the 5th valid cycle of a 4x3 run -> valid_o low the following cycle, no done_o, state IDLE. A new start then succeeds from sample 0.
- Write addr 2 := (0xFFFF0000, 0x00008000, 0x00010000) during RUN, then rerun -> the old addr 2 data is still streamed. Repeat the same write in IDLE -> the new values (-1.0, 0.5, 1.0) appear.
- Assert reset_i mid-run -> every output is 0 at the next edge. Restart without reloading -> the previously written samples are streamed unchanged.
